// File: rtl/uart_loopback_ctrl.sv
// Hardware echo engine between the UART receive and transmit buffers.
// Optional CR -> CR,LF expansion is enabled by defining UART_LOOPBACK_CRLF_EN.
module uart_loopback_ctrl #(
  parameter int UPCASE = 0,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [7:0]       rx_data_in,
  input  logic             rx_data_present,
  output logic             read_rx_data_ack,
  output logic [7:0]       tx_data_out,
  output logic             write_tx_data,
  input  logic             tx_buffer_full,
  output logic             busy,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] tx_count
);

`ifdef UART_LOOPBACK_CRLF_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACK     = 3'd1,
    SETTLE  = 3'd2,
    SEND    = 3'd3,
    DONE    = 3'd4,
    LF_SEND = 3'd5,
    DONE2   = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACK    = 3'd1,
    SETTLE = 3'd2,
    SEND   = 3'd3,
    DONE   = 3'd4
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             ack_q, ack_d;
  logic             write_q, write_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] rx_count_q, rx_count_d;
  logic [CNT_W-1:0] tx_count_q, tx_count_d;

  function automatic logic [7:0] conv_byte(input logic [7:0] b);
    if ((UPCASE != 0) && (b >= 8'h61) && (b <= 8'h7A)) begin
      return b - 8'h20;
    end else begin
      return b;
    end
  endfunction

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    ack_d      = 1'b0;
    write_d    = 1'b0;
    tx_data_d  = tx_data_q;
    rx_count_d = rx_count_q;
    tx_count_d = tx_count_q;
    case (state_q)
      IDLE: begin
        if (enable && rx_data_present && !tx_buffer_full) begin
          hold_d     = conv_byte(rx_data_in);
          ack_d      = 1'b1;
          rx_count_d = rx_count_q + CNT_W'(1);
          state_d    = ACK;
        end else begin
          state_d = IDLE;
        end
      end
      ACK: state_d = SETTLE;
      // The write pulse is issued on the edge entering SEND when tx has room,
      // otherwise SEND re-tries on every edge until it does.
      SETTLE, SEND: begin
        if ((state_q == SEND) && write_q) begin
          state_d = DONE;
        end else if (!tx_buffer_full) begin
          write_d    = 1'b1;
          tx_data_d  = hold_q;
          tx_count_d = tx_count_q + CNT_W'(1);
          state_d    = SEND;
        end else begin
          state_d = SEND;
        end
      end
`ifdef UART_LOOPBACK_CRLF_EN
      DONE: begin
        if (hold_q == 8'h0D) begin
          state_d = LF_SEND;
          if (!tx_buffer_full) begin
            write_d    = 1'b1;
            tx_data_d  = 8'h0A;
            tx_count_d = tx_count_q + CNT_W'(1);
          end else begin
            write_d = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LF_SEND: begin
        if (write_q) begin
          state_d = DONE2;
        end else if (!tx_buffer_full) begin
          write_d    = 1'b1;
          tx_data_d  = 8'h0A;
          tx_count_d = tx_count_q + CNT_W'(1);
        end else begin
          state_d = LF_SEND;
        end
      end
      DONE2: state_d = IDLE;
`else
      DONE: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_q     <= 8'h00;
      ack_q      <= 1'b0;
      write_q    <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      rx_count_q <= '0;
      tx_count_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      ack_q      <= ack_d;
      write_q    <= write_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      rx_count_q <= rx_count_d;
      tx_count_q <= tx_count_d;
    end
  end

  assign read_rx_data_ack = ack_q;
  assign write_tx_data    = write_q;
  assign tx_data_out      = tx_data_q;
  assign busy             = busy_q;
  assign rx_count         = rx_count_q;
  assign tx_count         = tx_count_q;

endmodule

// File: tb/tb_uart_loopback_ctrl.sv
// Bench for uart_loopback_ctrl: two instances (UPCASE=0/CNT_W=16 and UPCASE=1/CNT_W=4)
// share stimulus; a queue-based model of the rx buffer and expected tx stream checks them.
module tb_uart_loopback_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, present, full;
  logic [7:0]  rx_data;
  logic        ack0, wr0, busy0, ack1, wr1, busy1;
  logic [7:0]  txd0, txd1;
  logic [15:0] rxc0, txc0;
  logic [3:0]  rxc1, txc1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acks = 0;
  int writes = 0;
  int last_ack = -1;
  logic [7:0] rx_q[$];
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  int ack_cyc[$];
  int write_cyc[$];

  uart_loopback_ctrl #(.UPCASE(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .rx_data_in(rx_data),
    .rx_data_present(present), .read_rx_data_ack(ack0), .tx_data_out(txd0),
    .write_tx_data(wr0), .tx_buffer_full(full), .busy(busy0),
    .rx_count(rxc0), .tx_count(txc0)
  );

  uart_loopback_ctrl #(.UPCASE(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .rx_data_in(rx_data),
    .rx_data_present(present), .read_rx_data_ack(ack1), .tx_data_out(txd1),
    .write_tx_data(wr1), .tx_buffer_full(full), .busy(busy1),
    .rx_count(rxc1), .tx_count(txc1)
  );

  function automatic logic [7:0] ref_up(input logic [7:0] b);
    if (b inside {[8'h61:8'h7A]}) return b - 8'h20;
    return b;
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // One clock: sample at negedge, check against the model, then update the rx buffer model.
  task automatic step();
    logic [7:0] b;
    @(negedge clk);
    cyc++;
    if (reset) begin
      chk("rst_ack", ack0 | ack1, 0);
      chk("rst_write", wr0 | wr1, 0);
      chk("rst_txd0", txd0, 0);
      chk("rst_txd1", txd1, 0);
      chk("rst_busy", busy0 | busy1, 0);
      chk("rst_cnt0", {rxc0, txc0}, 0);
      chk("rst_cnt1", {rxc1, txc1}, 0);
      exp0.delete();
      exp1.delete();
      acks = 0;
      writes = 0;
    end else begin
      chk("ack_match", ack1, ack0);
      chk("wr_match", wr1, wr0);
      chk("no_overlap", ack0 & wr0, 0);
      if (ack0) begin
        chk("one_in_flight", exp0.size(), 0);
        chk("busy_on_ack", busy0, 1);
        if (rx_q.size() == 0) begin
          chk("ack_when_empty", 1, 0);
        end else begin
          b = rx_q.pop_front();
          acks++;
          last_ack = cyc;
          ack_cyc.push_back(cyc);
          exp0.push_back(b);
          exp1.push_back(ref_up(b));
`ifdef UART_LOOPBACK_CRLF_EN
          if (b == 8'h0D) begin
            exp0.push_back(8'h0A);
            exp1.push_back(8'h0A);
          end
`endif
        end
      end
      if (wr0) begin
        chk("write_while_full", full, 0);
        chk("busy_on_write", busy0, 1);
        if (exp0.size() == 0) begin
          chk("spurious_write", 1, 0);
        end else begin
          chk("tx_data0", txd0, exp0.pop_front());
          chk("tx_data1", txd1, exp1.pop_front());
          writes++;
          write_cyc.push_back(cyc);
        end
      end
      chk("rx_count0", rxc0, acks % 65536);
      chk("tx_count0", txc0, writes % 65536);
      chk("rx_count1", rxc1, acks % 16);
      chk("tx_count1", txc1, writes % 16);
    end
    present = (rx_q.size() != 0);
    rx_data = present ? rx_q[0] : 8'($urandom);
  endtask

  task automatic run_until_idle(input int max);
    int done = 0;
    for (int i = 0; i < max; i++) begin
      step();
      if (rx_q.size() == 0 && exp0.size() == 0 && !busy0 && !busy1) begin
        done = 1;
        break;
      end
    end
    chk("drain_timeout", done, 1);
  endtask

  task automatic wait_ack(input int max);
    int done = 0;
    for (int i = 0; i < max; i++) begin
      step();
      if (last_ack == cyc) begin
        done = 1;
        break;
      end
    end
    chk("ack_timeout", done, 1);
  endtask

  initial begin
    int w, a;
    reset = 1'b1; enable = 1'b0; full = 1'b0; present = 1'b0; rx_data = 8'h00;
    repeat (2) step();
    reset = 1'b0;
    step();
    chk("idle_busy", busy0, 0);
    enable = 1'b1;

    // Single byte: ack then write two cycles later.
    rx_q.push_back(8'h41); ack_cyc.delete(); write_cyc.delete();
    run_until_idle(50);
    chk("t1_acks", ack_cyc.size(), 1);
    chk("t1_writes", write_cyc.size(), 1);
    if (ack_cyc.size() == 1 && write_cyc.size() == 1)
      chk("t1_latency", write_cyc[0] - ack_cyc[0], 2);
    chk("t1_rxc", rxc0, 1);
    chk("t1_txc", txc0, 1);

    // Back-to-back: 5-cycle spacing.
    rx_q.push_back(8'h31); rx_q.push_back(8'h32); rx_q.push_back(8'h33);
    ack_cyc.delete(); write_cyc.delete();
    run_until_idle(80);
    chk("t2_acks", ack_cyc.size(), 3);
    chk("t2_writes", write_cyc.size(), 3);
    if (ack_cyc.size() == 3) begin
      chk("t2_space01", ack_cyc[1] - ack_cyc[0], 5);
      chk("t2_space12", ack_cyc[2] - ack_cyc[1], 5);
    end

    // Backpressure: hold full for 20 cycles after the ack of 0x55.
    rx_q.push_back(8'h55); rx_q.push_back(8'h66);
    wait_ack(20);
    full = 1'b1;
    w = writes; a = acks;
    repeat (20) step();
    chk("bp_no_write", writes, w);
    chk("bp_no_ack", acks, a);
    full = 1'b0;
    step();
    chk("bp_write_now", wr0, 1);
    chk("bp_data", txd0, 8'h55);
    run_until_idle(50);

    // Case conversion boundaries (checked on dut1 via the model).
    rx_q.push_back(8'h61); rx_q.push_back(8'h7A); rx_q.push_back(8'h5B);
    rx_q.push_back(8'h60); rx_q.push_back(8'h7B); rx_q.push_back(8'h40);
    run_until_idle(100);

    // Reset while in SETTLE drops the held 0x77.
    rx_q.push_back(8'h77);
    wait_ack(20);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    rx_q.push_back(8'h10);
    run_until_idle(50);
    chk("rst_rx_count", rxc0, 1);
    chk("rst_tx_count", txc0, 1);

    // Carriage return.
    w = writes;
    rx_q.push_back(8'h0D);
    run_until_idle(50);
`ifdef UART_LOOPBACK_CRLF_EN
    chk("cr_writes", writes - w, 2);
`else
    chk("cr_writes", writes - w, 1);
`endif

    // Randomized traffic with random backpressure and enable.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: rx_q.push_back(8'h0D);
        1: rx_q.push_back(8'($urandom_range(8'h5F, 8'h7C)));
        default: rx_q.push_back(8'($urandom));
      endcase
    end
    for (int i = 0; i < 1200; i++) begin
      full = ($urandom_range(0, 3) == 0);
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) rx_q.push_back(8'($urandom));
      step();
    end
    full = 1'b0;
    enable = 1'b1;
    run_until_idle(3000);
    chk("final_acks_wrapped", rxc1, acks % 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
